// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_pkg
// Purpose  : Shared constants, state encoding and field-packing helpers for
//            the instruction encoder.
// Revision : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Request class codes
    localparam logic [1:0] c_class_dp  = 2'b00;
    localparam logic [1:0] c_class_mem = 2'b01;
    localparam logic [1:0] c_class_br  = 2'b10;
    localparam logic [1:0] c_class_bx  = 2'b11;

    // Data-processing opcodes with forced fields
    localparam logic [3:0] c_cmd_cmp = 4'b1010;
    localparam logic [3:0] c_cmd_mov = 4'b1101;

    // BX fixed pattern occupying bits [27:4]
    localparam logic [23:0] c_bx_const = 24'h12FFF1;

    // Fixed memory-transfer bits: pre-index, add offset, word, no writeback
    localparam logic c_mem_p = 1'b1;
    localparam logic c_mem_u = 1'b1;
    localparam logic c_mem_b = 1'b0;
    localparam logic c_mem_w = 1'b0;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_search = 2'd1;
    localparam state_t c_st_out    = 2'd2;
    localparam state_t c_st_err    = 2'd3;

    function automatic logic [31:0] enc_dp_reg(
        input logic [3:0] cond, input logic [3:0] cmd, input logic s,
        input logic [3:0] rn, input logic [3:0] rd, input logic [4:0] shamt,
        input logic [1:0] sh, input logic [3:0] rm);
        return {cond, 2'b00, 1'b0, cmd, s, rn, rd, shamt, sh, 1'b0, rm};
    endfunction

    function automatic logic [31:0] enc_dp_imm(
        input logic [3:0] cond, input logic [3:0] cmd, input logic s,
        input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rot,
        input logic [7:0] imm8);
        return {cond, 2'b00, 1'b1, cmd, s, rn, rd, rot, imm8};
    endfunction

    function automatic logic [31:0] enc_mem(
        input logic [3:0] cond, input logic l, input logic [3:0] rn,
        input logic [3:0] rd, input logic [11:0] off);
        return {cond, 2'b01, 1'b0, c_mem_p, c_mem_u, c_mem_b, c_mem_w, l, rn, rd, off};
    endfunction

    function automatic logic [31:0] enc_branch(
        input logic [3:0] cond, input logic l, input logic [23:0] off);
        return {cond, 3'b101, l, off};
    endfunction

    function automatic logic [31:0] enc_bx(
        input logic [3:0] cond, input logic [3:0] rm);
        return {cond, c_bx_const, rm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_imm_rot_check.sv
`default_nettype none
// ============================================================================
// Module   : imm_rot_check
// Purpose  : Tests whether a 32-bit value, rotated left by 2*rot, fits in the
//            low 8 bits; returns the candidate 8-bit immediate.
// Revision : 1.0 - initial release
// ============================================================================
module imm_rot_check (
    input  logic [31:0] value,
    input  logic [3:0]  rot,
    output logic        fits,
    output logic [7:0]  imm8
);
    logic [4:0]  w_shift;
    logic [63:0] w_dbl;
    logic [31:0] w_rotated;

    // Rotate-left through a doubled word so a zero shift needs no special case
    always_comb begin
        w_shift   = {rot, 1'b0};
        w_dbl     = {value, value} << w_shift;
        w_rotated = w_dbl[63:32];
        fits      = (w_rotated[31:8] == 24'd0);
        imm8      = w_rotated[7:0];
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Encodes request descriptors into 32-bit ARM machine words and
//            presents them with a sequential write address. Immediate data-
//            processing operands are fitted by a one-rotation-per-cycle search.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_class,
    input  logic [3:0]        req_cond,
    input  logic [3:0]        req_cmd,
    input  logic              req_s,
    input  logic              req_imm,
    input  logic              req_l,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rm,
    input  logic [4:0]        req_shamt,
    input  logic [1:0]        req_sh,
    input  logic [31:0]       req_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    state_t      r_state;
    logic [3:0]  r_cond;
    logic [3:0]  r_cmd;
    logic        r_s;
    logic [3:0]  r_rn;
    logic [3:0]  r_rd;
    logic [3:0]  r_rot;
    logic [31:0] r_value;

    logic        w_s_eff;
    logic [3:0]  w_rn_eff;
    logic [3:0]  w_rd_eff;
    logic        w_mem_ok;
    logic        w_br_ok;
    logic        w_fits;
    logic [7:0]  w_imm8;

    assign req_ready = (r_state == c_st_idle);

    // CMP always sets flags and has no destination; MOV has no first operand
    always_comb begin
        w_s_eff  = req_s | (req_cmd == c_cmd_cmp);
        w_rd_eff = (req_cmd == c_cmd_cmp) ? 4'd0 : req_rd;
        w_rn_eff = (req_cmd == c_cmd_mov) ? 4'd0 : req_rn;
        w_mem_ok = (req_value[31:12] == 20'd0);
        w_br_ok  = (req_value[31:24] == {8{req_value[23]}});
    end

    imm_rot_check u_imm_rot_check (
        .value (r_value),
        .rot   (r_rot),
        .fits  (w_fits),
        .imm8  (w_imm8)
    );

    // Request acceptance, rotation search, output handshake and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_cond    <= 4'd0;
            r_cmd     <= 4'd0;
            r_s       <= 1'b0;
            r_rn      <= 4'd0;
            r_rd      <= 4'd0;
            r_rot     <= 4'd0;
            r_value   <= 32'd0;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_addr  <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_cond  <= req_cond;
                        r_cmd   <= req_cmd;
                        r_s     <= w_s_eff;
                        r_rn    <= w_rn_eff;
                        r_rd    <= w_rd_eff;
                        r_value <= req_value;
                        r_rot   <= 4'd0;
                        case (req_class)
                            c_class_dp: begin
                                if (req_imm) begin
                                    r_state <= c_st_search;
                                end else begin
                                    r_state   <= c_st_out;
                                    out_valid <= 1'b1;
                                    out_instr <= enc_dp_reg(req_cond, req_cmd, w_s_eff, w_rn_eff,
                                                            w_rd_eff, req_shamt, req_sh, req_rm);
                                end
                            end
                            c_class_mem: begin
                                if (w_mem_ok) begin
                                    r_state   <= c_st_out;
                                    out_valid <= 1'b1;
                                    out_instr <= enc_mem(req_cond, req_l, req_rn, req_rd,
                                                         req_value[11:0]);
                                end else begin
                                    r_state <= c_st_err;
                                    err     <= 1'b1;
                                end
                            end
                            c_class_br: begin
                                if (w_br_ok) begin
                                    r_state   <= c_st_out;
                                    out_valid <= 1'b1;
                                    out_instr <= enc_branch(req_cond, req_l, req_value[23:0]);
                                end else begin
                                    r_state <= c_st_err;
                                    err     <= 1'b1;
                                end
                            end
                            default: begin
                                r_state   <= c_st_out;
                                out_valid <= 1'b1;
                                out_instr <= enc_bx(req_cond, req_rm);
                            end
                        endcase
                    end
                end
                c_st_search: begin
                    if (w_fits) begin
                        r_state   <= c_st_out;
                        out_valid <= 1'b1;
                        out_instr <= enc_dp_imm(r_cond, r_cmd, r_s, r_rn, r_rd, r_rot, w_imm8);
                    end else if (r_rot == 4'd15) begin
                        r_state <= c_st_err;
                        err     <= 1'b1;
                    end else begin
                        r_rot <= r_rot + 4'd1;
                    end
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_state   <= c_st_idle;
                        out_valid <= 1'b0;
                        out_instr <= 32'd0;
                        out_addr  <= out_addr + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed self-checking bench for instr_encoder (ADDR_W = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_class = 2'b00;
    logic [3:0]        req_cond = 4'h0;
    logic [3:0]        req_cmd = 4'h0;
    logic              req_s = 1'b0;
    logic              req_imm = 1'b0;
    logic              req_l = 1'b0;
    logic [3:0]        req_rd = 4'h0;
    logic [3:0]        req_rn = 4'h0;
    logic [3:0]        req_rm = 4'h0;
    logic [4:0]        req_shamt = 5'd0;
    logic [1:0]        req_sh = 2'b00;
    logic [31:0]       req_value = 32'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_class (req_class),
        .req_cond  (req_cond),
        .req_cmd   (req_cmd),
        .req_s     (req_s),
        .req_imm   (req_imm),
        .req_l     (req_l),
        .req_rd    (req_rd),
        .req_rn    (req_rn),
        .req_rm    (req_rm),
        .req_shamt (req_shamt),
        .req_sh    (req_sh),
        .req_value (req_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for one clock; called shortly after a rising edge
    task automatic accept(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] cmd,
                          input logic s, input logic imm, input logic l, input logic [3:0] rd,
                          input logic [3:0] rn, input logic [3:0] rm, input logic [4:0] shamt,
                          input logic [1:0] sh, input logic [31:0] value);
        req_class = cls;  req_cond = cond; req_cmd = cmd; req_s = s; req_imm = imm;
        req_l = l; req_rd = rd; req_rn = rn; req_rm = rm; req_shamt = shamt; req_sh = sh;
        req_value = value;
        check("ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_value = 32'hDEAD_BEEF;
    endtask

    // Rising edges from acceptance edge (counted as 1) until out_valid or err
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && !err && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    int lat;
    int seen;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr",  {30'd0, out_addr}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);

        // DP register ADD
        accept(2'b00, 4'hE, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 5'd4, 2'b00, 32'd0);
        wait_result(lat);
        check("add_lat",   lat, 32'd1);
        check("add_instr", out_instr, 32'hE0821203);
        check("add_addr",  {30'd0, out_addr}, 32'd0);
        handshake();
        check("add_instr_cleared", out_instr, 32'd0);
        check("add_addr_inc", {30'd0, out_addr}, 32'd1);

        // DP immediate MOV, match at rotation 12
        accept(2'b00, 4'hE, 4'b1101, 1'b0, 1'b1, 1'b0, 4'd5, 4'd9, 4'd0, 5'd0, 2'b00, 32'h0000_3F00);
        wait_result(lat);
        check("mov_lat",   lat, 32'd14);
        check("mov_instr", out_instr, 32'hE3A05C3F);
        check("mov_addr",  {30'd0, out_addr}, 32'd1);
        handshake();

        // DP immediate not encodable
        accept(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 5'd0, 2'b00, 32'h0000_0101);
        wait_result(lat);
        check("noimm_lat",   lat, 32'd17);
        check("noimm_err",   {31'd0, err}, 32'd1);
        check("noimm_valid", {31'd0, out_valid}, 32'd0);
        check("noimm_addr",  {30'd0, out_addr}, 32'd2);
        @(posedge clk); #1;
        check("noimm_err_pulse", {31'd0, err}, 32'd0);

        // BX held under backpressure
        accept(2'b11, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd14, 5'd0, 2'b00, 32'd0);
        wait_result(lat);
        check("bx_lat", lat, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bx_hold_instr", out_instr, 32'hE12FFF1E);
            check("bx_hold_addr",  {30'd0, out_addr}, 32'd2);
            @(posedge clk); #1;
        end
        check("bx_hold_valid", {31'd0, out_valid}, 32'd1);
        handshake();

        // BL backwards by one word; address wraps afterwards
        accept(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 5'd0, 2'b00, 32'hFFFF_FFFF);
        wait_result(lat);
        check("bl_lat",   lat, 32'd1);
        check("bl_instr", out_instr, 32'hEBFFFFFF);
        check("bl_addr",  {30'd0, out_addr}, 32'd3);
        handshake();
        check("wrap_addr", {30'd0, out_addr}, 32'd0);

        // CMP immediate zero: S forced, Rd forced to 0, match at r=0
        accept(2'b00, 4'hE, 4'b1010, 1'b0, 1'b1, 1'b0, 4'd7, 4'd2, 4'd0, 5'd0, 2'b00, 32'd0);
        wait_result(lat);
        check("cmp_lat",   lat, 32'd2);
        check("cmp_instr", out_instr, 32'hE3520000);
        handshake();

        // Memory offset out of range
        accept(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0, 5'd0, 2'b00, 32'h0000_1000);
        wait_result(lat);
        check("mem_err_lat", lat, 32'd1);
        check("mem_err",     {31'd0, err}, 32'd1);
        check("mem_err_valid", {31'd0, out_valid}, 32'd0);

        @(posedge clk); #1;
        // Branch offset not sign-extendable
        accept(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 5'd0, 2'b00, 32'h0100_0000);
        wait_result(lat);
        check("br_err", {31'd0, err}, 32'd1);
        check("br_err_addr", {30'd0, out_addr}, 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a search
        accept(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 5'd0, 2'b00, 32'h0000_0101);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || err) seen++;
            @(posedge clk); #1;
        end
        check("rst_search_no_output", seen, 32'd0);
        check("rst_search_addr", {30'd0, out_addr}, 32'd0);
        check("rst_search_ready", {31'd0, req_ready}, 32'd1);

        // Five loads walk the 2-bit address space and wrap
        for (int i = 0; i < 5; i++) begin
            accept(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 5'd0, 2'b00, 32'd4);
            wait_result(lat);
            check("ldr_lat",   lat, 32'd1);
            check("ldr_instr", out_instr, 32'hE5901004);
            check("ldr_addr",  {30'd0, out_addr}, i % 4);
            handshake();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter: ADDR_W, default 10, width of the instruction-memory write address.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state changes on rising edge.
  reset  in  1  synchronous, active-high reset.
  req_valid  in  1  request word present.
  req_ready  out  1  encoder accepts request.
  req_class  in  2  00 data-processing, 01 memory, 10 branch, 11 BX.
  req_cond  in  4  condition field, bits [31:28].
  req_cmd  in  4  DP opcode.
  req_s  in  1  DP set-flags.
  req_imm  in  1  DP operand2 is immediate.
  req_l  in  1  memory: 1 LDR, 0 STR; branch: 1 BL.
  req_rd, req_rn, req_rm  in  4 each  register fields.
  req_shamt  in  5  DP register shift amount.
  req_sh  in  2  DP shift type.
  req_value  in  32  DP immediate, memory offset or branch word offset.
  out_valid  out  1  encoded word present.
  out_ready  in  1  instruction-memory writer accepts word.
  out_instr  out  32  encoded machine word.
  out_addr  out  ADDR_W  write address for out_instr.
  err  out  1  one-cycle pulse: request not encodable, dropped.

Function
REQ-003 SHALL run FSM states IDLE, SEARCH, OUT, ERR; req_ready=1 only in IDLE.
REQ-004 SHALL accept a request when req_valid&&req_ready and latch all req_* fields.
REQ-005 DP register form SHALL encode cond,00,0,cmd,S,Rn,Rd,shamt5,sh,0,Rm; OUT entered next cycle.
REQ-006 DP immediate form SHALL enter SEARCH and test one rotation per cycle, r=0..15, starting the cycle after acceptance; match when (value ROL 2r)[31:8]==0.
REQ-007 The smallest matching r SHALL win; encode cond,00,1,cmd,S,Rn,Rd,r[3:0],imm8; OUT entered the cycle after the match.
REQ-008 No match after r=15 SHALL go to ERR (acceptance + 17 cycles); value 0 SHALL match at r=0.
REQ-009 cmd 1010 (CMP) SHALL force S=1 and Rd=0; cmd 1101 (MOV) SHALL force Rn=0.
REQ-010 Memory SHALL encode cond,01,I=0,P=1,U=1,B=0,W=0,L,Rn,Rd,value[11:0]; value[31:12]!=0 SHALL go to ERR.
REQ-011 Branch SHALL encode cond,101,L,value[23:0]; value[31:24] not all equal to value[23] SHALL go to ERR.
REQ-012 BX SHALL encode cond,24'h12FFF1 in bits [27:4], Rm in [3:0]; other fields ignored.
REQ-013 In OUT, out_valid=1, out_instr and out_addr SHALL hold stable until out_ready; on out_valid&&out_ready, return to IDLE and increment out_addr.
REQ-014 out_addr SHALL wrap from 2^ADDR_W-1 to 0 without flag or stall.
REQ-015 ERR SHALL last exactly one cycle with err=1, then IDLE; out_addr SHALL be unchanged.
REQ-016 Latency, acceptance to out_valid: 1 cycle for non-search requests; r+2 cycles for DP immediate matching at rotation r.
REQ-017 out_instr SHALL be 0 whenever out_valid=0.

Reset
REQ-018 reset SHALL force state IDLE, req_ready=1, out_valid=0, out_instr=0, out_addr=0, err=0, rotation counter=0.
REQ-019 reset during SEARCH or OUT SHALL discard the pending word with no output and no err.

Structure
REQ-020 Shared package SHALL hold: class codes, CMP/MOV opcodes, BX constant 24'h12FFF1, fixed memory bits P/U/B/W, FSM state encoding.
REQ-021 One combinational sub-module imm_rot_check SHALL map (value, r) to (fits, imm8).

Verification
REQ-022 DP reg ADD, cond E, Rd=1, Rn=2, Rm=3, shamt 4, sh 00 -> out_instr 32'hE0821203 one cycle after accept, out_addr 0.
REQ-023 DP imm MOV value 32'h0000_3F00, Rd=5 -> match r=12, out_instr 32'hE3A05C3F, out_valid 14 cycles after accept.
REQ-024 DP imm value 32'h0000_0101 -> err pulse 17 cycles after accept, no out_valid, out_addr unchanged.
REQ-025 BX Rm=14, cond E, out_ready held 0 for 5 cycles -> out_instr 32'hE12FFF1E stable throughout; BL value -1 -> 32'hEBFFFFFF.
REQ-026 ADDR_W=2, five LDR Rn=0 Rd=1 offset 4 (32'hE5901004) -> addresses 0,1,2,3,0; reset asserted mid-SEARCH -> no output, out_addr 0.
